dds_multi_sequencer: RTL and testbench

- Parametrised successor of the single-rate instruction address counter.
- Generates NUM_CH independent block-RAM instruction addresses for the DDS channels: per-channel start delay, shared runtime step period, programmable last address, one-shot or loop mode, explicit start/stop control and status.
- Everything runs on the single system clock; there are no derived clocks.
- Sits between the control logic and the per-channel instruction ROMs; addr_o drives ROM addra directly.

---
 rtl/dds_multi_seq_pkg.sv | 15 +
 rtl/dds_multi_sequencer_if.sv | 27 ++
 rtl/dds_seq_channel.sv | 75 +++++++
 rtl/dds_multi_sequencer.sv | 97 +++++++++
 tb/tb_dds_multi_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dds_multi_seq_pkg.sv
// Shared types and defaults for the multi-channel DDS instruction sequencer.
package dds_multi_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  localparam int DEF_ADDR_W = 17;
  localparam int DEF_PER_W  = 16;
  localparam int DEF_DLY_W  = 32;

  // A zero period would never expire; treat it as one clock per step.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/dds_multi_sequencer_if.sv
// Control/config/status bundle between control logic and the DDS sequencer.
interface dds_multi_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 17,
  parameter int PER_W  = 16,
  parameter int DLY_W  = 32
);
  logic                     start_i;
  logic                     stop_i;
  logic                     loop_i;
  logic [PER_W-1:0]         period_i;
  logic [ADDR_W-1:0]        last_addr_i;
  logic [NUM_CH*DLY_W-1:0]  delay_i;
  logic [NUM_CH*ADDR_W-1:0] addr_o;
  logic [NUM_CH-1:0]        step_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output start_i, stop_i, loop_i, period_i, last_addr_i, delay_i,
    input  addr_o, step_o, busy_o, done_o
  );
  modport slave (
    input  start_i, stop_i, loop_i, period_i, last_addr_i, delay_i,
    output addr_o, step_o, busy_o, done_o
  );
endinterface

// File: rtl/dds_seq_channel.sv
// One sequencer channel: start delay, period counter, address register, finished flag.
module dds_seq_channel #(
  parameter int ADDR_W = 17,
  parameter int PER_W  = 16,
  parameter int DLY_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic              pause,
  input  logic              loop,
  input  logic [PER_W-1:0]  period,
  input  logic [ADDR_W-1:0] last,
  input  logic [DLY_W-1:0]  delay,
  output logic [ADDR_W-1:0] addr,
  output logic              step,
  output logic              finished
);
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fin_q, fin_d, step_q, step_d;

  always_comb begin
    dly_d  = dly_q;
    per_d  = per_q;
    addr_d = addr_q;
    fin_d  = fin_q;
    step_d = 1'b0;
    if (clear) begin
      dly_d  = '0;
      per_d  = '0;
      addr_d = '0;
      fin_d  = 1'b0;
    end else if (run && !pause && !fin_q) begin
      if (dly_q != delay) begin
        dly_d = dly_q + DLY_W'(1);
      end else if (per_q != period - PER_W'(1)) begin
        per_d = per_q + PER_W'(1);
      end else begin
        per_d  = '0;
        step_d = 1'b1;
        // addr==last without loop only happens for last==0: finish holding 0.
        if (addr_q == last) begin
          addr_d = '0;
          fin_d  = !loop;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          fin_d  = !loop && (addr_q + ADDR_W'(1) == last);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q  <= '0;
      per_q  <= '0;
      addr_q <= '0;
      fin_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      dly_q  <= dly_d;
      per_q  <= per_d;
      addr_q <= addr_d;
      fin_q  <= fin_d;
      step_q <= step_d;
    end
  end

  assign addr     = addr_q;
  assign step     = step_q;
  assign finished = fin_q;
endmodule

// File: rtl/dds_multi_sequencer.sv
// NUM_CH-channel DDS instruction address sequencer: FSM, config latches, channel array.
// Optional run-time freeze via DDS_MULTI_SEQUENCER_PAUSE_EN (adds pause_i).
module dds_multi_sequencer
  import dds_multi_seq_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PER_W  = DEF_PER_W,
  parameter int DLY_W  = DEF_DLY_W
) (
  input  logic clk,
  input  logic reset,
`ifdef DDS_MULTI_SEQUENCER_PAUSE_EN
  input  logic pause_i,
`endif
  dds_multi_sequencer_if.slave bus
);
  seq_state_e              state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    loop_q, loop_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic [ADDR_W-1:0]       last_q, last_d;
  logic [NUM_CH*DLY_W-1:0] delay_q, delay_d;
  logic [NUM_CH-1:0]       fin;
  logic                    launch, clear_ch, run_ch, pause;

`ifdef DDS_MULTI_SEQUENCER_PAUSE_EN
  assign pause = pause_i;
`else
  assign pause = 1'b0;
`endif

  assign launch   = (state_q != RUN) && bus.start_i && !bus.stop_i;
  assign clear_ch = launch || bus.stop_i;
  assign run_ch   = (state_q == RUN) && !bus.stop_i;

  always_comb begin
    state_d  = state_q;
    loop_d   = loop_q;
    period_d = period_q;
    last_d   = last_q;
    delay_d  = delay_q;
    if (bus.stop_i) begin
      state_d = IDLE;
    end else if (launch) begin
      state_d  = RUN;
      loop_d   = bus.loop_i;
      period_d = PER_W'(clamp_period(32'(bus.period_i)));
      last_d   = bus.last_addr_i;
      delay_d  = bus.delay_i;
    end else if (state_q == RUN && &fin) begin
      state_d = DONE;
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      period_q <= PER_W'(1);
      last_q   <= '0;
      delay_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      loop_q   <= loop_d;
      period_q <= period_d;
      last_q   <= last_d;
      delay_q  <= delay_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dds_seq_channel #(.ADDR_W(ADDR_W), .PER_W(PER_W), .DLY_W(DLY_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_ch),
      .run      (run_ch),
      .pause    (pause),
      .loop     (loop_q),
      .period   (period_q),
      .last     (last_q),
      .delay    (delay_q[i*DLY_W +: DLY_W]),
      .addr     (bus.addr_o[i*ADDR_W +: ADDR_W]),
      .step     (bus.step_o[i]),
      .finished (fin[i])
    );
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_dds_multi_sequencer.sv
// Directed bench for dds_multi_sequencer (NUM_CH=2); k counts edges after the start edge.
module tb_dds_multi_sequencer;
  logic clk = 1'b0;
  logic reset;
`ifdef DDS_MULTI_SEQUENCER_PAUSE_EN
  logic pause_i;
`endif
  int n_run = 0;
  int n_fail = 0;
  int kk = 0;

  dds_multi_sequencer_if #(.NUM_CH(2), .ADDR_W(17), .PER_W(16), .DLY_W(32)) bus ();

  dds_multi_sequencer #(.NUM_CH(2), .ADDR_W(17), .PER_W(16), .DLY_W(32)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef DDS_MULTI_SEQUENCER_PAUSE_EN
    .pause_i (pause_i),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] ad(input int c);
    return bus.addr_o[c*17 +: 17];
  endfunction

  task automatic go(input int k);
    repeat (k - kk) @(negedge clk);
    kk = k;
  endtask

  task automatic launch(input logic lp, input logic [15:0] per, input logic [16:0] last,
                        input logic [31:0] d0, input logic [31:0] d1);
    bus.loop_i      = lp;
    bus.period_i    = per;
    bus.last_addr_i = last;
    bus.delay_i     = {d1, d0};
    bus.start_i     = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    // later config changes must be ignored until the next start
    bus.period_i    = 16'd3;
    bus.last_addr_i = 17'd9;
    bus.delay_i     = '0;
    kk = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr0"}, ad(0), 0);
    chk({tag, "_addr1"}, ad(1), 0);
    chk({tag, "_step"},  bus.step_o, 0);
    chk({tag, "_busy"},  bus.busy_o, 0);
    chk({tag, "_done"},  bus.done_o, 0);
  endtask

  // One-shot scenario: period 10, last 3, delays {0,5}
  task automatic run_oneshot(input string tag);
    launch(1'b0, 16'd10, 17'd3, 32'd0, 32'd5);
    chk({tag, "_k0_busy"}, bus.busy_o, 1);
    chk({tag, "_k0_addr1"}, ad(1), 0);
    go(9);  chk({tag, "_k9_addr0"}, ad(0), 0);
    go(10); chk({tag, "_k10_addr0"}, ad(0), 1);
            chk({tag, "_k10_step"}, bus.step_o, 2'b01);
    go(15); chk({tag, "_k15_addr1"}, ad(1), 1);
            chk({tag, "_k15_step"}, bus.step_o, 2'b10);
    go(20); chk({tag, "_k20_addr0"}, ad(0), 2);
    go(30); chk({tag, "_k30_addr0"}, ad(0), 3);
    go(35); chk({tag, "_k35_addr1"}, ad(1), 3);
            chk({tag, "_k35_busy"}, bus.busy_o, 1);
            chk({tag, "_k35_done"}, bus.done_o, 0);
    go(36); chk({tag, "_k36_done"}, bus.done_o, 1);
            chk({tag, "_k36_busy"}, bus.busy_o, 0);
    go(40); chk({tag, "_hold_addr0"}, ad(0), 3);
            chk({tag, "_hold_addr1"}, ad(1), 3);
            chk({tag, "_hold_step"}, bus.step_o, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.loop_i = 1'b0;
    bus.period_i = '0; bus.last_addr_i = '0; bus.delay_i = '0;
`ifdef DDS_MULTI_SEQUENCER_PAUSE_EN
    pause_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    run_oneshot("os");
    run_oneshot("relaunch");

    // start and stop together in DONE -> IDLE
    bus.start_i = 1'b1; bus.stop_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.stop_i = 1'b0;
    check_idle("startstop");
    @(negedge clk);
    chk("startstop_still_idle", bus.busy_o, 0);

    // loop mode: period 4, last 2
    launch(1'b1, 16'd4, 17'd2, 32'd0, 32'd0);
    go(3);  chk("loop_k3_addr", ad(0), 0);
    go(4);  chk("loop_k4_addr", ad(0), 1);
    go(8);  chk("loop_k8_addr", ad(0), 2);
    go(12); chk("loop_k12_addr", ad(0), 0);
            chk("loop_k12_step", bus.step_o, 2'b11);
    go(13); chk("loop_k13_step", bus.step_o, 0);
    go(16); chk("loop_k16_addr", ad(1), 1);
    go(40); chk("loop_k40_done", bus.done_o, 0);
            chk("loop_k40_busy", bus.busy_o, 1);
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    check_idle("loop_stop");

    // period 0 behaves as period 1
    launch(1'b0, 16'd0, 17'd3, 32'd0, 32'd0);
    go(1); chk("p0_k1_addr", ad(0), 1);
           chk("p0_k1_step", bus.step_o, 2'b11);
    go(2); chk("p0_k2_addr", ad(1), 2);
    go(3); chk("p0_k3_addr", ad(0), 3);
           chk("p0_k3_done", bus.done_o, 0);
    go(4); chk("p0_k4_done", bus.done_o, 1);

    // last 0, one-shot
    launch(1'b0, 16'd2, 17'd0, 32'd0, 32'd0);
    go(1); chk("l0_k1_step", bus.step_o, 0);
    go(2); chk("l0_k2_step", bus.step_o, 2'b11);
           chk("l0_k2_addr", ad(0), 0);
           chk("l0_k2_busy", bus.busy_o, 1);
    go(3); chk("l0_k3_done", bus.done_o, 1);
           chk("l0_k3_step", bus.step_o, 0);

    // reset mid-RUN, sampled at edge T+17
    launch(1'b0, 16'd10, 17'd3, 32'd0, 32'd5);
    go(16); chk("rst_k16_addr0", ad(0), 1);
    reset = 1'b1;
    go(17); check_idle("rst_mid");
    reset = 1'b0;
    go(20); chk("rst_after_busy", bus.busy_o, 0);

`ifdef DDS_MULTI_SEQUENCER_PAUSE_EN
    // pause high across edges T+12..T+18
    launch(1'b0, 16'd10, 17'd3, 32'd0, 32'd5);
    go(11); pause_i = 1'b1;
    go(18); pause_i = 1'b0;
    go(20); chk("pause_k20_addr0", ad(0), 1);
    go(26); chk("pause_k26_step", bus.step_o[0], 0);
    go(27); chk("pause_k27_addr0", ad(0), 2);
            chk("pause_k27_step", bus.step_o[0], 1);
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
